cpld_uart_ctrl: RTL and testbench

- Bus-side controller for the CPLD serial controller on the Thinpad board; lives inside riscv_soc between the SoC's MMIO decoder and the board-level UART pins.
- Generates uart_rdn/uart_wrn pulses and drives/samples the low 8 bits of base_ram_data, which it shares with BaseRAM.
- Asserts a busy/hold flag so the BaseRAM controller deselects the SRAM while a UART transfer owns the data bus.
- Exposes a data register and a status register to the CPU through a single-request/ack handshake.

---
 rtl/cpld_uart_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cpld_uart_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld_uart_ctrl.sv
// cpld_uart_ctrl
//   Bus-side controller for the Thinpad CPLD serial controller. Turns single
//   CPU request/ack transactions into uart_rdn / uart_wrn strobe sequences on
//   the low byte of base_ram_data, which is shared with BaseRAM. While a
//   transfer owns the bus, busy tells the BaseRAM controller to deselect the
//   SRAM.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   req, we, addr      CPU request (sampled in idle only), write flag,
//                      register select (0 = data, 1 = status)
//   wdata / rdata      byte to transmit / read result (valid with ack)
//   ack                one-cycle completion pulse
//   busy               high from request accept through ack
//   uart_rdn/uart_wrn  CPLD read / write strobes, active-low
//   uart_dataready     async: receive byte available
//   uart_tbre          async: transmit buffer empty
//   uart_tsre          async: transmit shift register empty
//   data_i             base_ram_data[7:0] as seen at the pad
//   data_o, data_oe    value and tristate enable for base_ram_data[7:0]
//
// All outputs are set on entry to the state that owns them, so every output
// comes straight from a flop.
module cpld_uart_ctrl #(
    parameter int unsigned RD_CYCLES = 3,
    parameter int unsigned WR_SETUP  = 1,
    parameter int unsigned WR_CYCLES = 3,
    parameter int unsigned WR_HOLD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_dataready,
    input  logic       uart_tbre,
    input  logic       uart_tsre,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWaitTx,
        StWrS,
        StWrL,
        StWrH,
        StDone
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] wbyte_q;

    logic [1:0] rx_sync_q;
    logic [1:0] tbre_sync_q;
    logic [1:0] tsre_sync_q;

    logic       rx_rdy;
    logic       tx_rdy;
    logic [7:0] status;

    // Two-flop synchronizers for the asynchronous CPLD status lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q   <= 2'b00;
            tbre_sync_q <= 2'b00;
            tsre_sync_q <= 2'b00;
        end else begin
            rx_sync_q   <= {rx_sync_q[0], uart_dataready};
            tbre_sync_q <= {tbre_sync_q[0], uart_tbre};
            tsre_sync_q <= {tsre_sync_q[0], uart_tsre};
        end
    end

    assign rx_rdy = rx_sync_q[1];
    assign tx_rdy = tbre_sync_q[1] & tsre_sync_q[1];
    assign status = {6'b0, rx_rdy, tx_rdy};

    // cnt_q is loaded with (phase length - 1) on entry to each timed phase
    // and the phase ends in the cycle it reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            wbyte_q  <= 8'd0;
            rdata    <= 8'd0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            uart_rdn <= 1'b1;
            uart_wrn <= 1'b1;
            data_o   <= 8'd0;
            data_oe  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    ack <= 1'b0;
                    if (req) begin
                        busy <= 1'b1;
                        if (addr) begin
                            rdata   <= status;
                            ack     <= 1'b1;
                            state_q <= StDone;
                        end else if (we) begin
                            wbyte_q <= wdata;
                            state_q <= StWaitTx;
                        end else if (rx_rdy) begin
                            uart_rdn <= 1'b0;
                            cnt_q    <= 8'(RD_CYCLES - 1);
                            state_q  <= StRd;
                        end else begin
                            // Nothing received: complete without a strobe.
                            rdata   <= 8'h00;
                            ack     <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end

                StRd: begin
                    if (cnt_q == 8'd0) begin
                        // Last low cycle: capture the pad before releasing rdn.
                        rdata    <= data_i;
                        uart_rdn <= 1'b1;
                        ack      <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StWaitTx: begin
                    if (tx_rdy) begin
                        data_o  <= wbyte_q;
                        data_oe <= 1'b1;
                        cnt_q   <= 8'(WR_SETUP - 1);
                        state_q <= StWrS;
                    end
                end

                StWrS: begin
                    if (cnt_q == 8'd0) begin
                        uart_wrn <= 1'b0;
                        cnt_q    <= 8'(WR_CYCLES - 1);
                        state_q  <= StWrL;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StWrL: begin
                    if (cnt_q == 8'd0) begin
                        uart_wrn <= 1'b1;
                        cnt_q    <= 8'(WR_HOLD - 1);
                        state_q  <= StWrH;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StWrH: begin
                    if (cnt_q == 8'd0) begin
                        data_oe <= 1'b0;
                        ack     <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StDone: begin
                    ack     <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// tb_cpld_uart_ctrl
//   Directed bench for cpld_uart_ctrl. Latencies are counted with the cycle in
//   which req is sampled as cycle 1, so a status read acks in cycle 2.
module tb_cpld_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       we;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic       uart_rdn;
    logic       uart_wrn;
    logic       uart_dataready;
    logic       uart_tbre;
    logic       uart_tsre;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;

    int errors = 0;
    int checks = 0;

    // Observed at negedge, away from the active edge.
    int   rdn_low  = 0;
    int   wrn_fall = 0;
    int   ack_cnt  = 0;
    int   viol     = 0;
    logic wrn_prev = 1'b1;

    cpld_uart_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .ack            (ack),
        .busy           (busy),
        .uart_rdn       (uart_rdn),
        .uart_wrn       (uart_wrn),
        .uart_dataready (uart_dataready),
        .uart_tbre      (uart_tbre),
        .uart_tsre      (uart_tsre),
        .data_i         (data_i),
        .data_o         (data_o),
        .data_oe        (data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!uart_rdn) rdn_low <= rdn_low + 1;
        if (!uart_wrn && wrn_prev) wrn_fall <= wrn_fall + 1;
        wrn_prev <= uart_wrn;
        if (ack) ack_cnt <= ack_cnt + 1;
        if ((!uart_rdn && !uart_wrn) || (!uart_rdn && data_oe)) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request, req dropped after the accept edge; lat = cycle of ack.
    task automatic xfer(input logic w, input logic a, input logic [7:0] wd, output int lat);
        we    = w;
        addr  = a;
        wdata = wd;
        req   = 1'b1;
        step();
        req = 1'b0;
        lat = 2;
        while (!ack && lat < 100) begin
            step();
            lat++;
        end
        if (!ack) check("ack_timeout", 32'(ack), 32'd1);
    endtask

    int lat;
    int prev;
    int n;

    initial begin
        rst            = 1'b1;
        req            = 1'b0;
        we             = 1'b0;
        addr           = 1'b0;
        wdata          = 8'h00;
        uart_dataready = 1'b0;
        uart_tbre      = 1'b0;
        uart_tsre      = 1'b0;
        data_i         = 8'h00;
        repeat (3) step();

        // Reset state.
        check("rst_rdn", 32'(uart_rdn), 32'd1);
        check("rst_wrn", 32'(uart_wrn), 32'd1);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_data_o", 32'(data_o), 32'h00);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Status read: rx ready, tx not ready (tsre low) -> 8'h02.
        uart_dataready = 1'b1;
        uart_tbre      = 1'b1;
        uart_tsre      = 1'b0;
        repeat (3) step();
        prev = rdn_low;
        n    = wrn_fall;
        xfer(1'b0, 1'b1, 8'h00, lat);
        check("stat_lat", 32'(lat), 32'd2);
        check("stat_rdata", 32'(rdata), 32'h02);
        check("stat_busy", 32'(busy), 32'd1);
        check("stat_rdn_low", 32'(rdn_low - prev), 32'd0);
        check("stat_wrn_fall", 32'(wrn_fall - n), 32'd0);
        step();
        check("stat_ack_clr", 32'(ack), 32'd0);
        check("stat_busy_clr", 32'(busy), 32'd0);

        // Data read with a byte present.
        data_i = 8'hA5;
        prev   = rdn_low;
        xfer(1'b0, 1'b0, 8'h00, lat);
        check("rd_lat", 32'(lat), 32'd5);
        check("rd_rdata", 32'(rdata), 32'hA5);
        check("rd_rdn_high", 32'(uart_rdn), 32'd1);
        check("rd_rdn_low", 32'(rdn_low - prev), 32'd3);
        step();

        // Empty read: no strobe, rdata 0.
        uart_dataready = 1'b0;
        repeat (3) step();
        prev = rdn_low;
        xfer(1'b0, 1'b0, 8'h00, lat);
        check("empty_lat", 32'(lat), 32'd2);
        check("empty_rdata", 32'(rdata), 32'h00);
        check("empty_rdn_low", 32'(rdn_low - prev), 32'd0);
        step();

        // Blocked write: tsre low keeps it waiting.
        we    = 1'b1;
        addr  = 1'b0;
        wdata = 8'h3C;
        req   = 1'b1;
        step();
        req   = 1'b0;
        wdata = 8'h00;
        repeat (5) step();
        check("blk_busy", 32'(busy), 32'd1);
        check("blk_wrn", 32'(uart_wrn), 32'd1);
        check("blk_oe", 32'(data_oe), 32'd0);
        check("blk_ack", 32'(ack), 32'd0);
        uart_tsre = 1'b1;
        n = 0;
        while (!data_oe && n < 10) begin
            step();
            n++;
        end
        check("blk_oe_seen", 32'(data_oe), 32'd1);
        check("blk_setup_data", 32'(data_o), 32'h3C);
        check("blk_setup_wrn", 32'(uart_wrn), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("blk_wrn_low", 32'(uart_wrn), 32'd0);
            check("blk_low_oe", 32'(data_oe), 32'd1);
        end
        step();
        check("blk_hold_wrn", 32'(uart_wrn), 32'd1);
        check("blk_hold_oe", 32'(data_oe), 32'd1);
        check("blk_hold_data", 32'(data_o), 32'h3C);
        check("blk_hold_ack", 32'(ack), 32'd0);
        step();
        check("blk_ack", 32'(ack), 32'd1);
        check("blk_done_oe", 32'(data_oe), 32'd0);
        step();

        // Write with tx ready: full latency.
        n = wrn_fall;
        xfer(1'b1, 1'b0, 8'h5A, lat);
        check("wr_lat", 32'(lat), 32'd8);
        check("wr_data", 32'(data_o), 32'h5A);
        check("wr_fall", 32'(wrn_fall - n), 32'd1);
        step();

        // Back-to-back writes with req held high.
        n     = wrn_fall;
        we    = 1'b1;
        addr  = 1'b0;
        wdata = 8'h55;
        req   = 1'b1;
        step();
        prev = 0;
        while (!ack && prev < 50) begin
            step();
            prev++;
        end
        check("b2b_ack1", 32'(ack), 32'd1);
        check("b2b_busy_ack1", 32'(busy), 32'd1);
        check("b2b_data1", 32'(data_o), 32'h55);
        step();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_ack", 32'(ack), 32'd0);
        wdata = 8'hAA;
        step();
        check("b2b_busy2", 32'(busy), 32'd1);
        prev = 0;
        while (!ack && prev < 50) begin
            step();
            prev++;
        end
        req = 1'b0;
        check("b2b_ack2", 32'(ack), 32'd1);
        check("b2b_data2", 32'(data_o), 32'hAA);
        check("b2b_falls", 32'(wrn_fall - n), 32'd2);
        step();
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Reset mid-write while uart_wrn is low.
        we    = 1'b1;
        addr  = 1'b0;
        wdata = 8'hC3;
        req   = 1'b1;
        step();
        req = 1'b0;
        n   = 0;
        while (uart_wrn && n < 20) begin
            step();
            n++;
        end
        check("mid_wrn_low", 32'(uart_wrn), 32'd0);
        prev = ack_cnt;
        rst  = 1'b1;
        step();
        check("mid_rst_wrn", 32'(uart_wrn), 32'd1);
        check("mid_rst_oe", 32'(data_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check("mid_no_ack", 32'(ack_cnt - prev), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_wrn_after", 32'(uart_wrn), 32'd1);

        check("strobe_overlap", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
